// File: rtl/spi_flash_stream.sv
// SPI NOR/EEPROM read streamer: sends CMD and address, then streams WORD_W-bit
// words to a valid/ready consumer. SCLK is divided from clk and pauses on back-pressure.
module spi_flash_stream #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned SCLK_HALF = 1,
  parameter logic [7:0]  CMD       = 8'h03,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] IN_addr,
  input  logic [15:0]       IN_len,
  input  logic              IN_start,
  input  logic              IN_cancel,
  input  logic              IN_ready,
  output logic [WORD_W-1:0] OUT_word,
  output logic              OUT_wordValid,
  output logic              OUT_busy,
  output logic              OUT_done,
  output logic              OUT_sclk,
  output logic              OUT_cs,
  output logic              OUT_mosi,
  input  logic              IN_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int unsigned TXW  = 8 + ADDR_W;
  localparam int unsigned HW   = $clog2(SCLK_HALF + 1);
  localparam int unsigned GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned MAXB = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
  localparam int unsigned BW   = $clog2(MAXB);

  localparam logic [HW-1:0] HALF    = HW'(SCLK_HALF);
  localparam logic [HW-1:0] HALF_M1 = HW'(SCLK_HALF - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(CS_GAP - 1);

  logic [2:0]        state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [TXW-1:0]    tx_q, tx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [15:0]       len_q, len_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              go_gap;
  logic              len_hit;
  logic [WORD_W-1:0] full_word;

  // The counter is compared after it has been registered, so the transfer ends
  // one cycle after the final word loads; that cycle is still a SCLK-low phase.
  assign len_hit = (len_q != 16'd0) && (wcnt_q == len_q);

  // Next-state logic: bit timing, shifting, holding register and word count.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    gcnt_d    = gcnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    go_gap    = 1'b0;
    full_word = {shift_q[WORD_W-2:0], IN_miso};

    if (valid_q && IN_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (IN_start && !IN_cancel) begin
          state_d = S_CMD;
          cs_d    = 1'b0;
          tx_d    = {CMD, IN_addr};
          mosi_d  = CMD[7];
          len_d   = IN_len;
          wcnt_d  = 16'd0;
          bcnt_d  = '0;
          // One extra cycle of CS-low lead-in before the first low phase.
          hcnt_d  = HALF;
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        if (IN_cancel || (state_q == S_DATA && len_hit)) begin
          go_gap = 1'b1;
        end else if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - HW'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          hcnt_d = HALF_M1;
        end else begin
          // End of the high phase: sample MISO, start next bit's low phase.
          sclk_d = 1'b0;
          hcnt_d = HALF_M1;
          bcnt_d = bcnt_q + BW'(1);
          if (state_q == S_DATA) begin
            shift_d = full_word;
            if (bcnt_q == BW'(WORD_W - 1)) begin
              bcnt_d = '0;
              if (!valid_q || IN_ready) begin
                word_d  = full_word;
                valid_d = 1'b1;
                wcnt_d  = wcnt_q + 16'd1;
              end else begin
                state_d = S_STALL;
              end
            end
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[TXW-2];
            if (state_q == S_CMD && bcnt_q == BW'(7)) begin
              state_d = S_ADDR;
              bcnt_d  = '0;
            end else if (state_q == S_ADDR && bcnt_q == BW'(ADDR_W - 1)) begin
              state_d = S_DATA;
              bcnt_d  = '0;
              mosi_d  = 1'b0;
            end
          end
        end
      end

      S_STALL: begin
        sclk_d = 1'b0;
        if (IN_cancel) begin
          go_gap = 1'b1;
        end else if (valid_q && IN_ready) begin
          word_d  = shift_q;
          valid_d = 1'b1;
          wcnt_d  = wcnt_q + 16'd1;
          state_d = S_DATA;
          hcnt_d  = HALF_M1;
        end
      end

      S_GAP: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go_gap) begin
      state_d = S_GAP;
      cs_d    = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      gcnt_d  = GAP_M1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      tx_q    <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= 16'd0;
      len_q   <= 16'd0;
      gcnt_q  <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      gcnt_q  <= gcnt_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign OUT_word      = word_q;
  assign OUT_wordValid = valid_q;
  assign OUT_busy      = (state_q != S_IDLE);
  assign OUT_done      = done_q;
  assign OUT_sclk      = sclk_q;
  assign OUT_cs        = cs_q;
  assign OUT_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_flash_stream.sv
// Bench for spi_flash_stream: two instances (default and SCLK_HALF=3/WORD_W=16)
// each talking to a behavioural SPI flash model.
module tb_spi_flash_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] addr0 = '0, addr1 = '0;
  logic [15:0] len0 = '0, len1 = '0;
  logic        start0 = 0, cancel0 = 0, ready0 = 0;
  logic        start1 = 0, cancel1 = 0, ready1 = 0;
  logic [31:0] word0;
  logic [15:0] word1;
  logic        valid0, busy0, done0, sclk0, cs0, mosi0;
  logic        valid1, busy1, done1, sclk1, cs1, mosi1;
  logic [1:0]  sclk_v, cs_v, mosi_v, miso_v;

  assign sclk_v = {sclk1, sclk0};
  assign cs_v   = {cs1, cs0};
  assign mosi_v = {mosi1, mosi0};

  spi_flash_stream dut0 (
    .clk(clk), .rst(rst), .IN_addr(addr0), .IN_len(len0), .IN_start(start0),
    .IN_cancel(cancel0), .IN_ready(ready0), .OUT_word(word0), .OUT_wordValid(valid0),
    .OUT_busy(busy0), .OUT_done(done0), .OUT_sclk(sclk0), .OUT_cs(cs0),
    .OUT_mosi(mosi0), .IN_miso(miso_v[0])
  );

  spi_flash_stream #(.SCLK_HALF(3), .WORD_W(16)) dut1 (
    .clk(clk), .rst(rst), .IN_addr(addr1), .IN_len(len1), .IN_start(start1),
    .IN_cancel(cancel1), .IN_ready(ready1), .OUT_word(word1), .OUT_wordValid(valid1),
    .OUT_busy(busy1), .OUT_done(done1), .OUT_sclk(sclk1), .OUT_cs(cs1),
    .OUT_mosi(mosi1), .IN_miso(miso_v[1])
  );

  // Flash contents: a fixed signature at 0x100, arithmetic pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hDE;
      24'h000101: return 8'hAD;
      24'h000102: return 8'hBE;
      24'h000103: return 8'hEF;
      default:    return a[7:0] * 8'd37 + a[15:8] + 8'h11;
    endcase
  endfunction

  // Word n of a read at address a, wb bytes per word, MSB = lowest address.
  function automatic logic [31:0] exp_word(input logic [23:0] a, input int unsigned n,
                                           input int unsigned wb);
    logic [31:0] w = '0;
    for (int unsigned j = 0; j < wb; j++)
      w = {w[23:0], mem_byte(a + 24'(n * wb + j))};
    return w;
  endfunction

  // SPI mode-0 flash: capture MOSI on SCLK rise, drive MISO after SCLK fall.
  for (genvar g = 0; g < 2; g++) begin : g_flash
    int          nbits = 0;
    int          k;
    logic [63:0] cap = '0;
    logic [7:0]  cmd_cap = '0;
    logic [23:0] addr_cap = '0;
    logic [7:0]  b;
    logic        miso_r = 1'b0;
    assign miso_v[g] = miso_r;

    always @(posedge sclk_v[g] or posedge cs_v[g]) begin
      if (cs_v[g] === 1'b1) begin
        nbits = 0;
      end else begin
        cap   = {cap[62:0], mosi_v[g]};
        nbits = nbits + 1;
        if (nbits == 1) begin cmd_cap = '0; addr_cap = '0; end
        if (nbits == 32) begin cmd_cap = cap[31:24]; addr_cap = cap[23:0]; end
      end
    end

    always @(negedge sclk_v[g] or posedge cs_v[g]) begin
      if (cs_v[g] === 1'b1) begin
        miso_r = 1'b0;
      end else if (nbits >= 32) begin
        k      = nbits - 32;
        b      = mem_byte(addr_cap + 24'(k / 8));
        miso_r = b[7 - (k % 8)];
      end
    end
  end

  // Consumer-side monitor: collect accepted words, count done pulses, hold check.
  logic [31:0] rx0[$];
  logic [31:0] rx1[$];
  int          done_cnt0 = 0;
  int          stab_err = 0;
  logic        hold0 = 1'b0;
  logic [31:0] held0 = '0;

  always @(negedge clk) begin
    if (rst && valid0 && ready0) rx0.push_back(word0);
    if (rst && valid1 && ready1) rx1.push_back({16'h0, word1});
    if (rst && done0) done_cnt0++;
    if (rst && hold0 && valid0 && word0 !== held0) stab_err++;
    hold0 = rst && valid0 && !ready0;
    held0 = word0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run one dut0 transfer with random consumer readiness, then check it.
  task automatic run0(input logic [23:0] a, input logic [15:0] n, input int unsigned pct,
                      input logic [31:0] first, input string tag);
    int d0;
    bit seen;
    rx0.delete();
    d0 = done_cnt0;
    addr0 = a; len0 = n; start0 = 1'b1;
    ready0 = ($urandom_range(99) < pct);
    step(1);
    start0 = 1'b0;
    seen = 0;
    for (int c = 0; c < 64 * int'(n) * 6 + 400 && !seen; c++) begin
      step(1);
      ready0 = ($urandom_range(99) < pct);
      if (done0) seen = 1;
    end
    ready0 = 1'b1;
    step(3);
    chk({tag, " done seen"}, 64'(seen), 1);
    chk({tag, " done count"}, 64'(done_cnt0 - d0), 1);
    chk({tag, " cmd"}, 64'(g_flash[0].cmd_cap), 8'h03);
    chk({tag, " addr"}, 64'(g_flash[0].addr_cap), 64'(a));
    chk({tag, " words"}, 64'(rx0.size()), 64'(n));
    if (rx0.size() > 0) chk({tag, " first"}, 64'(rx0[0]), 64'(first));
    for (int i = 1; i < rx0.size(); i++)
      chk($sformatf("%s w%0d", tag, i), 64'(rx0[i]), 64'(exp_word(a, i, 4)));
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    int unsigned pct;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vt[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, viol, c;
    bit seen;

    vt[0] = '{24'h000100, 16'd3, 100, 32'hDEADBEEF};
    vt[1] = '{24'h00FFFE, 16'd4, 70, exp_word(24'h00FFFE, 0, 4)};
    vt[2] = '{24'hABCDEF, 16'd5, 40, exp_word(24'hABCDEF, 0, 4)};
    vt[3] = '{24'hFFFFFC, 16'd2, 60, exp_word(24'hFFFFFC, 0, 4)};

    // Reset values
    step(3);
    chk("rst cs", 64'(cs0), 1);
    chk("rst sclk", 64'(sclk0), 0);
    chk("rst mosi", 64'(mosi0), 0);
    chk("rst valid", 64'(valid0), 0);
    chk("rst word", 64'(word0), 0);
    chk("rst busy", 64'(busy0), 0);
    chk("rst done", 64'(done0), 0);
    rst = 1'b1;
    step(2);

    // Exact timing of a single-word read at 0x100
    rx0.delete();
    addr0 = 24'h000100; len0 = 16'd1; ready0 = 1'b1; start0 = 1'b1;
    step(1); start0 = 1'b0;                  // after E0
    chk("t0 cs low", 64'(cs0), 0);
    chk("t0 busy", 64'(busy0), 1);
    step(1); chk("t1 sclk", 64'(sclk0), 0);
    step(1); chk("t2 sclk rise", 64'(sclk0), 1);
    step(126); chk("t128 valid", 64'(valid0), 0);
    step(1);
    chk("t129 valid", 64'(valid0), 1);
    chk("t129 word", 64'(word0), 32'hDEADBEEF);
    chk("t129 cs", 64'(cs0), 0);
    step(1);
    chk("t130 valid", 64'(valid0), 0);
    chk("t130 cs high", 64'(cs0), 1);
    step(1);
    chk("t131 done", 64'(done0), 0);
    chk("t131 busy", 64'(busy0), 1);
    step(1);
    chk("t132 done", 64'(done0), 1);
    chk("t132 busy", 64'(busy0), 0);
    step(1); chk("t133 done", 64'(done0), 0);
    chk("t cmd", 64'(g_flash[0].cmd_cap), 8'h03);
    chk("t addr", 64'(g_flash[0].addr_cap), 24'h000100);
    chk("t words", 64'(rx0.size()), 1);
    step(3);

    // Back-pressure: 4 words, consumer idle until 200 cycles after word 0
    rx0.delete();
    addr0 = 24'h002000; len0 = 16'd4; ready0 = 1'b0; start0 = 1'b1;
    step(1); start0 = 1'b0;
    step(129);
    chk("bp w0 valid", 64'(valid0), 1);
    chk("bp w0 word", 64'(word0), 64'(exp_word(24'h002000, 0, 4)));
    step(71);
    viol = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (sclk0 !== 1'b0 || cs0 !== 1'b0) viol++;
    end
    chk("bp stall sclk/cs", 64'(viol), 0);
    chk("bp held valid", 64'(valid0), 1);
    chk("bp held word", 64'(word0), 64'(exp_word(24'h002000, 0, 4)));
    step(9);
    ready0 = 1'b1;
    seen = 0;
    for (c = 0; c < 800 && !seen; c++) begin
      step(1);
      if (done0) seen = 1;
    end
    step(2);
    chk("bp done", 64'(seen), 1);
    chk("bp words", 64'(rx0.size()), 4);
    for (int i = 0; i < rx0.size(); i++)
      chk($sformatf("bp w%0d", i), 64'(rx0[i]), 64'(exp_word(24'h002000, i, 4)));

    // Second instance: SCLK_HALF=3, WORD_W=16
    rx1.delete();
    addr1 = 24'h003456; len1 = 16'd2; ready1 = 1'b1; start1 = 1'b1;
    step(1); start1 = 1'b0;
    step(3); chk("s3 sclk p3", 64'(sclk1), 0);
    step(1); chk("s3 sclk p4", 64'(sclk1), 1);
    step(2); chk("s3 sclk p6", 64'(sclk1), 1);
    step(1); chk("s3 sclk p7", 64'(sclk1), 0);
    step(2); chk("s3 sclk p9", 64'(sclk1), 0);
    step(1); chk("s3 sclk p10", 64'(sclk1), 1);
    step(278); chk("s3 p288 valid", 64'(valid1), 0);
    step(1);
    chk("s3 p289 valid", 64'(valid1), 1);
    chk("s3 p289 word", 64'(word1), 64'(exp_word(24'h003456, 0, 2)));
    seen = 0;
    for (c = 0; c < 400 && !seen; c++) begin
      step(1);
      if (done1) seen = 1;
    end
    step(2);
    chk("s3 done", 64'(seen), 1);
    chk("s3 cmd", 64'(g_flash[1].cmd_cap), 8'h03);
    chk("s3 addr", 64'(g_flash[1].addr_cap), 24'h003456);
    chk("s3 words", 64'(rx1.size()), 2);
    for (int i = 0; i < rx1.size(); i++)
      chk($sformatf("s3 w%0d", i), 64'(rx1[i]), 64'(exp_word(24'h003456, i, 2)));

    // Table-driven transfers with random readiness
    for (int v = 0; v < 4; v++)
      run0(vt[v].addr, vt[v].len, vt[v].pct, vt[v].exp_first, $sformatf("vec%0d", v));

    // Unbounded stream, cancelled mid-word
    rx0.delete();
    d0 = done_cnt0;
    addr0 = 24'h004000; len0 = 16'd0; ready0 = 1'b1; start0 = 1'b1;
    step(1); start0 = 1'b0;
    for (c = 0; c < 2000 && rx0.size() < 5; c++) step(1);
    chk("unb reached 5", 64'(rx0.size()), 5);
    step(20);
    cancel0 = 1'b1;
    step(1); cancel0 = 1'b0;
    chk("unb cancel cs", 64'(cs0), 1);
    chk("unb cancel sclk", 64'(sclk0), 0);
    step(10);
    chk("unb busy", 64'(busy0), 0);
    chk("unb done count", 64'(done_cnt0 - d0), 1);
    chk("unb words", 64'(rx0.size()), 5);
    for (int i = 0; i < rx0.size(); i++)
      chk($sformatf("unb w%0d", i), 64'(rx0[i]), 64'(exp_word(24'h004000, i, 4)));

    // Cancel with a pending word: it survives into IDLE
    rx0.delete();
    addr0 = 24'h005000; len0 = 16'd0; ready0 = 1'b0; start0 = 1'b1;
    step(1); start0 = 1'b0;
    step(150);
    cancel0 = 1'b1;
    step(1); cancel0 = 1'b0;
    step(10);
    chk("pend busy", 64'(busy0), 0);
    chk("pend valid", 64'(valid0), 1);
    chk("pend word", 64'(word0), 64'(exp_word(24'h005000, 0, 4)));
    ready0 = 1'b1;
    step(2);
    chk("pend drained", 64'(valid0), 0);
    chk("pend count", 64'(rx0.size()), 1);

    // Start with cancel in the same IDLE cycle: no transfer
    addr0 = 24'h00AAAA; len0 = 16'd1; start0 = 1'b1; cancel0 = 1'b1;
    step(1); start0 = 1'b0; cancel0 = 1'b0;
    chk("sc busy", 64'(busy0), 0);
    chk("sc cs", 64'(cs0), 1);
    step(3);
    chk("sc busy later", 64'(busy0), 0);

    // Start while busy is ignored
    rx0.delete();
    addr0 = 24'h006000; len0 = 16'd1; ready0 = 1'b1; start0 = 1'b1;
    step(1); start0 = 1'b0;
    step(5);
    addr0 = 24'h007777; start0 = 1'b1;
    step(1); start0 = 1'b0;
    seen = 0;
    for (c = 0; c < 400 && !seen; c++) begin
      step(1);
      if (done0) seen = 1;
    end
    chk("sb done", 64'(seen), 1);
    step(3);
    chk("sb idle after", 64'(busy0), 0);
    chk("sb addr", 64'(g_flash[0].addr_cap), 24'h006000);
    chk("sb words", 64'(rx0.size()), 1);
    if (rx0.size() > 0) chk("sb w0", 64'(rx0[0]), 64'(exp_word(24'h006000, 0, 4)));

    // Asynchronous reset during the address phase
    addr0 = 24'hFFFFFF; len0 = 16'd2; ready0 = 1'b0; start0 = 1'b1;
    step(1); start0 = 1'b0;
    step(20);
    chk("ar in addr busy", 64'(busy0), 1);
    chk("ar in addr mosi", 64'(mosi0), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar cs", 64'(cs0), 1);
    chk("ar sclk", 64'(sclk0), 0);
    chk("ar mosi", 64'(mosi0), 0);
    chk("ar busy", 64'(busy0), 0);
    chk("ar valid", 64'(valid0), 0);
    chk("ar word", 64'(word0), 0);
    chk("ar done", 64'(done0), 0);
    step(2);
    rst = 1'b1;
    step(2);
    run0(24'h009ABC, 16'd2, 100, exp_word(24'h009ABC, 0, 4), "after rst");

    chk("hold stability", 64'(stab_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
